autosym_scan_engine: RTL
========================

AUTOSYM_SCAN_ENGINE -- requirements
Module: autosym_scan_engine

Interface
REQ-001 SHALL have parameter NIN, default 7, number of function inputs x0..x(NIN-1), range 2..8.
REQ-002 SHALL have parameter LDW, default 8, load beat width; power of 2, LDW <= 2^NIN.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ld_valid  in  1  load beat offered.
REQ-007 ld_ready  out  1  load beat accepted when ld_valid&ld_ready.
REQ-008 ld_data  in  LDW  truth-table bits; bit j of beat b = T[b*LDW+j].
REQ-009 start  in  1  scan request, sampled in IDLE only.
REQ-010 ev_x  in  NIN  evaluation input vector.
REQ-011 ev_y  out  1  registered T[ev_x].
REQ-012 tbl_ok  out  1  complete table loaded.
REQ-013 busy  out  1  scan in progress.
REQ-014 done  out  1  one-cycle pulse, results valid.
REQ-015 lin_map  out  2^NIN  bit a = 1 iff f(x^a)=f(x) for all x.
REQ-016 deg  out  clog2(NIN+1)  autosymmetry degree k = log2(popcount(lin_map)).

Function
REQ-017 SHALL hold the truth table T (2^NIN bits) in a register.
REQ-018 SHALL implement states IDLE, LOAD, SCAN, DONE.
REQ-019 ld_ready SHALL be 1 in IDLE and LOAD, 0 in SCAN and DONE.
REQ-020 Accepted beat in IDLE SHALL clear tbl_ok, write beat 0, and enter LOAD.
REQ-021 LOAD SHALL write accepted beats in order; beats without ld_valid SHALL stall, not advance.
REQ-022 After beat 2^NIN/LDW-1 is accepted, the FSM SHALL set tbl_ok=1 next cycle and return to IDLE.
REQ-023 start in IDLE with tbl_ok=1 SHALL enter SCAN with a=0, clear lin_map, set busy=1; otherwise start SHALL be ignored.
REQ-024 If start and ld_valid coincide in IDLE, the load beat SHALL win and start SHALL be ignored.
REQ-025 Each SCAN cycle SHALL evaluate one a, comparing all 2^NIN table bits with T[x^a] in parallel, and write lin_map[a].
REQ-026 lin_map[0] SHALL always be 1.
REQ-027 After a=2^NIN-1, the FSM SHALL enter DONE: busy=0, done=1 for one cycle, deg valid; then IDLE.
REQ-028 done SHALL assert exactly 2^NIN+1 cycles after the edge that samples start.
REQ-029 The a counter SHALL be NIN+1 bits wide and SHALL NOT wrap into a second pass.
REQ-030 lin_map and deg SHALL hold their values until the next accepted start or rst.
REQ-031 ev_y SHALL equal T[ev_x] one cycle after ev_x is applied, in every state, including mid-load with partial contents.
REQ-032 start and ld_valid SHALL be ignored while in SCAN or DONE.

Reset
REQ-033 rst SHALL force IDLE, clear T, set a=0, and drive ev_y, tbl_ok, busy, done, lin_map, and deg to 0.
REQ-034 rst SHALL win over every other input in the same cycle.
REQ-035 rst mid-LOAD or mid-SCAN SHALL abort with no done pulse; the table SHALL be reloaded before the next scan.

Verification
REQ-036 NIN=7, all-zero table loaded (16 beats of 0x00), start -> done at +129 cycles, lin_map all ones, deg=7.
REQ-037 Table f=x0 (beats 0xAA), start -> lin_map=1 at even indices only, deg=6.
REQ-038 Table f=x0&x1 (beats 0x88), start -> lin_map=1 iff a[1:0]=00, deg=5.
REQ-039 start with tbl_ok=0 -> busy stays 0, no done; start together with first load beat -> load proceeds, no scan.
REQ-040 rst asserted 50 cycles into a scan -> busy=0, lin_map=0, deg=0, no done pulse, tbl_ok=0.
REQ-041 Table f=x0, ev_x=1 -> ev_y=1 next cycle; ev_x=2 -> ev_y=0 next cycle, including during SCAN.

Source files
------------

// File: rtl/autosym_scan_engine.sv
// Linear-structure (autosymmetry) scanner: loads a 2^NIN-bit truth table, then tests every shift a for f(x^a)==f(x).
// Scan of all shifts takes 2^NIN+1 cycles after start; ld_ready drops while scanning so loads stall upstream.
module autosym_scan_engine #(
  parameter int NIN = 7,
  parameter int LDW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [LDW-1:0]               ld_data,
  input  logic                         start,
  input  logic [NIN-1:0]               ev_x,
  output logic                         ev_y,
  output logic                         tbl_ok,
  output logic                         busy,
  output logic                         done,
  output logic [2**NIN-1:0]            lin_map,
  output logic [$clog2(NIN+1)-1:0]     deg
);

  localparam int TBL   = 2**NIN;
  localparam int NBEAT = TBL / LDW;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int DW    = $clog2(NIN+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TBL-1:0]  tbl_q, tbl_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NIN:0]    a_q, a_d;
  logic            tbl_ok_q, tbl_ok_d;
  logic [TBL-1:0]  lin_map_q, lin_map_d;
  logic [DW-1:0]   deg_q, deg_d;
  logic            ev_y_q, ev_y_d;

  logic [TBL-1:0]  perm;
  logic            match;
  logic [NIN:0]    pop;
  logic [DW-1:0]   deg_calc;
  logic            last_beat;

  // Table permuted by the current shift; a full-width compare decides one lin_map bit per cycle.
  always_comb begin
    perm = '0;
    for (int x = 0; x < TBL; x++) begin
      perm[x] = tbl_q[x[NIN-1:0] ^ a_q[NIN-1:0]];
    end
    match = (perm == tbl_q);
  end

  // The set of linear structures is a subspace, so its size is a power of two and the top set bit is the degree.
  always_comb begin
    pop = '0;
    for (int i = 0; i < TBL; i++) begin
      pop = pop + (NIN+1)'(lin_map_q[i]);
    end
    deg_calc = '0;
    for (int i = 0; i <= NIN; i++) begin
      if (pop[i]) deg_calc = DW'(i);
    end
  end

  assign last_beat = (bcnt_q == BW'(NBEAT-1));

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    bcnt_d    = bcnt_q;
    a_d       = a_q;
    tbl_ok_d  = tbl_ok_q;
    lin_map_d = lin_map_q;
    deg_d     = deg_q;
    ev_y_d    = tbl_q[ev_x];
    case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          tbl_d[LDW-1:0] = ld_data;
          if (NBEAT == 1) begin
            tbl_ok_d = 1'b1;
            bcnt_d   = '0;
          end else begin
            tbl_ok_d = 1'b0;
            bcnt_d   = BW'(1);
            state_d  = S_LOAD;
          end
        end else if (start && tbl_ok_q) begin
          a_d       = '0;
          lin_map_d = '0;
          deg_d     = '0;
          state_d   = S_SCAN;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          tbl_d[int'(bcnt_q)*LDW +: LDW] = ld_data;
          if (last_beat) begin
            tbl_ok_d = 1'b1;
            bcnt_d   = '0;
            state_d  = S_IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_SCAN: begin
        // Extra counter bit marks the pass complete; lin_map is final here, so latch the degree.
        if (a_q[NIN]) begin
          deg_d   = deg_calc;
          state_d = S_DONE;
        end else begin
          lin_map_d[a_q[NIN-1:0]] = match;
          a_d = a_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tbl_q     <= '0;
      bcnt_q    <= '0;
      a_q       <= '0;
      tbl_ok_q  <= 1'b0;
      lin_map_q <= '0;
      deg_q     <= '0;
      ev_y_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tbl_q     <= tbl_d;
      bcnt_q    <= bcnt_d;
      a_q       <= a_d;
      tbl_ok_q  <= tbl_ok_d;
      lin_map_q <= lin_map_d;
      deg_q     <= deg_d;
      ev_y_q    <= ev_y_d;
    end
  end

  assign ld_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy     = (state_q == S_SCAN);
  assign done     = (state_q == S_DONE);
  assign tbl_ok   = tbl_ok_q;
  assign lin_map  = lin_map_q;
  assign deg      = deg_q;
  assign ev_y     = ev_y_q;

endmodule
